nn_stream_seq: RTL and testbench

- Bit-serial stimulus sequencer on the driving side of the nn ALU/aggregator datapath.
- Accepts one parallel weight vector and one input vector per neuron over a valid/ready handshake.
- Streams the pair LSB-first, one bit per clock, onto the ALU operand pins (alu_in_a_lsb, alu_op).
- After the last bit, captures the aggregator output (agg_out2alu) and presents it as a result with a valid/ready handshake.

---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_piso.sv | 53 +++++
 rtl/nn_stream_seq.sv | 109 ++++++++++
 tb/tb_nn_stream_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the nn stimulus sequencer slice.
//   NN_N_IN   default neuron fan-in (bits per vector)
//   NN_ACC_W  aggregator/result width of the nn datapath
//   nn_state_e sequencer FSM state encoding
package nn_pkg;

    localparam int NN_N_IN  = 16;
    localparam int NN_ACC_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } nn_state_e;

endpackage

// File: rtl/nn_piso.sv
// Dual parallel-in/serial-out register pair with a bit-index counter.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture w_in/x_in and clear the bit counter
//   shift         shift both registers right by one, advance the counter
//   w_in, x_in    parallel weight / activation vectors
//   w_lsb, x_lsb  current bit 0 of each register
//   cnt           index of the bit currently on w_lsb/x_lsb
//   last          cnt points at the final bit (N_IN-1)
module nn_piso
    import nn_pkg::*;
#(
    parameter int N_IN  = NN_N_IN,
    parameter int CNT_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [N_IN-1:0]  w_in,
    input  logic [N_IN-1:0]  x_in,
    output logic             w_lsb,
    output logic             x_lsb,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [N_IN-1:0]  w_sh;
    logic [N_IN-1:0]  x_sh;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_sh  <= '0;
            x_sh  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            w_sh  <= w_in;
            x_sh  <= x_in;
            cnt_q <= '0;
        end else if (shift) begin
            w_sh  <= {1'b0, w_sh[N_IN-1:1]};
            x_sh  <= {1'b0, x_sh[N_IN-1:1]};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign w_lsb = w_sh[0];
    assign x_lsb = x_sh[0];
    assign cnt   = cnt_q;
    assign last  = (cnt_q == CNT_W'(N_IN - 1));

endmodule

// File: rtl/nn_stream_seq.sv
// Bit-serial stimulus sequencer for the nn ALU/aggregator datapath.
// Accepts a weight/activation vector pair, streams it LSB-first onto the
// ALU operand pins, then captures the aggregator output as a result.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   vec_valid/vec_ready  vector-pair handshake
//   vec_w, vec_x         weight and activation vectors (bit 0 streamed first)
//   dp_a_lsb, dp_op      serial operand bits to the ALU
//   dp_en                operand bits are valid and must be accumulated
//   acc_clr              clears the aggregator; coincides with bit 0
//   dp_acc               aggregator output (signed)
//   res_valid/res_ready  result handshake
//   res_data             bit-exact copy of dp_acc captured after the stream
module nn_stream_seq
    import nn_pkg::*;
#(
    parameter int N_IN  = NN_N_IN,
    parameter int ACC_W = NN_ACC_W,
    parameter int CNT_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N_IN-1:0]  vec_w,
    input  logic [N_IN-1:0]  vec_x,
    output logic             dp_a_lsb,
    output logic             dp_op,
    output logic             dp_en,
    output logic             acc_clr,
    input  logic [ACC_W-1:0] dp_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);

    nn_state_e        state, state_nxt;
    logic             rdy_q;
    logic [ACC_W-1:0] res_q;
    logic             load, shift;
    logic             w_lsb, x_lsb, last;
    logic [CNT_W-1:0] cnt;

    nn_piso #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .w_in  (vec_w),
        .x_in  (vec_x),
        .w_lsb (w_lsb),
        .x_lsb (x_lsb),
        .cnt   (cnt),
        .last  (last)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vec_valid && rdy_q) begin
                    load      = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                shift = 1'b1;
                if (last) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Ready is a flop tracking "next state is IDLE" so that it stays low
    // through reset and rises only on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rdy_q <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == ST_IDLE);
            // SETTLE covers the aggregator's register latency, so dp_acc
            // already includes the final bit here.
            if (state == ST_SETTLE) res_q <= dp_acc;
        end
    end

    // Outputs decode directly from flops; the shift registers are zero
    // outside a stream, but the bits are gated anyway for clarity.
    assign vec_ready = rdy_q;
    assign dp_en     = (state == ST_STREAM);
    assign dp_a_lsb  = dp_en & w_lsb;
    assign dp_op     = dp_en & x_lsb;
    assign acc_clr   = dp_en && (cnt == '0);
    assign res_valid = (state == ST_HOLD);
    assign res_data  = res_q;

endmodule

// File: tb/tb_nn_stream_seq.sv
module tb_nn_stream_seq;

    localparam int N  = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vec_valid = 1'b0;
    logic          vec_ready;
    logic [N-1:0]  vec_w = '0;
    logic [N-1:0]  vec_x = '0;
    logic          dp_a_lsb, dp_op, dp_en, acc_clr;
    logic [AW-1:0] dp_acc;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    nn_stream_seq #(
        .N_IN  (N),
        .ACC_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_w     (vec_w),
        .vec_x     (vec_x),
        .dp_a_lsb  (dp_a_lsb),
        .dp_op     (dp_op),
        .dp_en     (dp_en),
        .acc_clr   (acc_clr),
        .dp_acc    (dp_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    // Aggregator stand-in: counts a&op bits, clear has priority, 1-cycle latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) dp_acc <= '0;
        else      dp_acc <= (acc_clr ? '0 : dp_acc) + AW'(dp_en & dp_a_lsb & dp_op);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dp_en"}, 32'(dp_en), 0);
        check({tag, "_acc_clr"}, 32'(acc_clr), 0);
        check({tag, "_dp_a"}, 32'(dp_a_lsb), 0);
        check({tag, "_dp_op"}, 32'(dp_op), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
    endtask

    // Called at a negedge; returns at the negedge of the first STREAM cycle.
    task automatic send(input logic [N-1:0] w, input logic [N-1:0] x);
        int unsigned n = 0;
        vec_w = w;
        vec_x = x;
        vec_valid = 1'b1;
        while (!vec_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready) check("send_timeout", 32'(vec_ready), 1);
        else exp_q.push_back(AW'($countones(w & x)));
        @(posedge clk);
        #1 vec_valid = 1'b0;
        @(negedge clk);
    endtask

    // Called in the first STREAM cycle; returns at the negedge of the HOLD cycle.
    task automatic stream_check(input logic [N-1:0] w, input logic [N-1:0] x);
        for (int i = 0; i < N; i++) begin
            check($sformatf("bit%0d_dp_en", i), 32'(dp_en), 1);
            check($sformatf("bit%0d_dp_a", i), 32'(dp_a_lsb), 32'(w[i]));
            check($sformatf("bit%0d_dp_op", i), 32'(dp_op), 32'(x[i]));
            check($sformatf("bit%0d_acc_clr", i), 32'(acc_clr), (i == 0) ? 1 : 0);
            check($sformatf("bit%0d_vec_ready", i), 32'(vec_ready), 0);
            check($sformatf("bit%0d_res_valid", i), 32'(res_valid), 0);
            @(negedge clk);
        end
        check_idle_outputs("settle");
        @(negedge clk);
        check("hold_res_valid", 32'(res_valid), 1);
        check("hold_vec_ready", 32'(vec_ready), 0);
    endtask

    // Called in HOLD; completes the result handshake, returns in IDLE.
    task automatic collect();
        logic [AW-1:0] e;
        res_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("res_valid", 32'(res_valid), 1);
        check("res_data", 32'(res_data), 32'(e));
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("post_res_valid", 32'(res_valid), 0);
        check("post_vec_ready", 32'(vec_ready), 1);
    endtask

    initial begin
        // Reset held with vec_valid asserted
        vec_valid = 1'b1;
        vec_w = 4'b1111;
        vec_x = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("rst");
            check("rst_vec_ready", 32'(vec_ready), 0);
            check("rst_res_data", 32'(res_data), 0);
        end
        rst = 1'b1;
        #1 check("rel_vec_ready_pre", 32'(vec_ready), 0);
        @(posedge clk);
        #1 vec_valid = 1'b0;
        @(negedge clk);
        check("rel_vec_ready", 32'(vec_ready), 1);
        check("rel_dp_en", 32'(dp_en), 0);

        // Basic stream + result
        send(4'b1011, 4'b0110);
        stream_check(4'b1011, 4'b0110);
        collect();

        // All ones -> 4
        send(4'b1111, 4'b1111);
        stream_check(4'b1111, 4'b1111);
        collect();

        // Backpressure in HOLD
        send(4'b0111, 4'b1101);
        stream_check(4'b0111, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 1);
            check("bp_res_data", 32'(res_data), 2);
            check("bp_vec_ready", 32'(vec_ready), 0);
        end
        collect();

        // Busy rejection: second vector presented during STREAM
        send(4'b1001, 4'b1011);
        vec_valid = 1'b1;
        vec_w = 4'b0110;
        vec_x = 4'b0111;
        stream_check(4'b1001, 4'b1011);
        collect();
        send(4'b0110, 4'b0111);
        stream_check(4'b0110, 4'b0111);
        collect();

        // Reset mid-stream after the 2nd bit
        send(4'b1111, 4'b1010);
        check("ms_bit0_op", 32'(dp_op), 0);
        @(negedge clk);
        check("ms_bit1_op", 32'(dp_op), 1);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_idle_outputs("abort");
        check("abort_vec_ready", 32'(vec_ready), 0);
        check("abort_res_data", 32'(res_data), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_res", 32'(res_valid), 0);
            check("abort_no_en", 32'(dp_en), 0);
        end
        check("abort_vec_ready_back", 32'(vec_ready), 1);
        send(4'b1110, 4'b0111);
        stream_check(4'b1110, 4'b0111);
        collect();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
